// File: rtl/ysyx_22040750_csr_ctrl_pkg.sv
// Shared definitions for the machine-mode CSR controller: CSR addresses,
// request type encodings, op_sel bit positions, mstatus fields and FSM states.
package ysyx_22040750_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  typedef enum logic [1:0] {
    REQ_CSR   = 2'b00,
    REQ_ECALL = 2'b01,
    REQ_MRET  = 2'b10,
    REQ_RSVD  = 2'b11
  } req_type_e;

  // One-hot op_sel layout {rw, rs, rc, rwi, rsi, rci}
  localparam int OP_RW  = 5;
  localparam int OP_RS  = 4;
  localparam int OP_RC  = 3;
  localparam int OP_RWI = 2;
  localparam int OP_RSI = 1;
  localparam int OP_RCI = 0;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [63:0] MSTATUS_RESET = 64'h0000_000a_0000_1800;

  typedef enum logic [2:0] {
    IDLE,
    CSR_RD,
    CSR_WR,
    TRAP_EPC,
    TRAP_CAUSE,
    TRAP_STAT,
    RET,
    RESP
  } state_e;

endpackage

// File: rtl/ysyx_22040750_csr_ctrl_if.sv
// Request/response bus between the execute stage (master) and the CSR
// controller (slave).
interface ysyx_22040750_csr_ctrl_if #(parameter int XLEN = 64);
  logic            I_req_valid;
  logic            O_req_ready;
  logic [1:0]      I_req_type;
  logic [11:0]     I_csr_addr;
  logic [5:0]      I_csr_op_sel;
  logic [XLEN-1:0] I_rs_data;
  logic [4:0]      I_uimm;
  logic [XLEN-1:0] I_pc;
  logic            O_resp_valid;
  logic            I_resp_ready;
  logic [XLEN-1:0] O_rd_data;
  logic            O_illegal;
  logic            O_redirect_valid;
  logic [XLEN-1:0] O_redirect_pc;

  modport master (
    output I_req_valid, I_req_type, I_csr_addr, I_csr_op_sel, I_rs_data,
           I_uimm, I_pc, I_resp_ready,
    input  O_req_ready, O_resp_valid, O_rd_data, O_illegal,
           O_redirect_valid, O_redirect_pc
  );

  modport slave (
    input  I_req_valid, I_req_type, I_csr_addr, I_csr_op_sel, I_rs_data,
           I_uimm, I_pc, I_resp_ready,
    output O_req_ready, O_resp_valid, O_rd_data, O_illegal,
           O_redirect_valid, O_redirect_pc
  );
endinterface

// File: rtl/ysyx_22040750_csr_ctrl_alu.sv
// Combinational CSR read-modify-write ALU: set/clear/write of the old CSR
// value with either rs1 or the zero-extended zimm as operand.
module ysyx_22040750_csr_alu
  import ysyx_22040750_csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] csr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [4:0]      uimm,
  input  logic [5:0]      op_sel,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] operand;

  // Pick the operand, then apply write / set / clear; read-only leaves csr as-is
  always_comb begin
    operand = rs_data;
    result  = csr;
    if (op_sel[OP_RWI] | op_sel[OP_RSI] | op_sel[OP_RCI])
      operand = {{(XLEN-5){1'b0}}, uimm};
    if (op_sel[OP_RW] | op_sel[OP_RWI])
      result = operand;
    else if (op_sel[OP_RS] | op_sel[OP_RSI])
      result = csr | operand;
    else if (op_sel[OP_RC] | op_sel[OP_RCI])
      result = csr & ~operand;
  end

endmodule

// File: rtl/ysyx_22040750_csr_ctrl.sv
// Machine-mode CSR controller: serialises CSR read-modify-write, ecall trap
// entry and mret trap return, and owns mstatus/mtvec/mepc/mcause.
// Optional feature: define YSYX_22040750_CSR_MSCRATCH_EN to implement mscratch.
module ysyx_22040750_csr_ctrl
  import ysyx_22040750_csr_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] MCAUSE_ECALL = XLEN'(11)
) (
  input logic                      I_sys_clk,
  input logic                      I_rst,
  ysyx_22040750_csr_ctrl_if.slave  bus
);

  state_e          state, next_state;
  logic [11:0]     addr_q;
  logic [5:0]      op_q;
  logic [XLEN-1:0] rs_q;
  logic [4:0]      uimm_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] old_q;
  logic            illegal_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic [XLEN-1:0] mstatus, mtvec, mepc, mcause;
`ifdef YSYX_22040750_CSR_MSCRATCH_EN
  logic [XLEN-1:0] mscratch;
`endif

  logic            rd_hit;
  logic [XLEN-1:0] rd_val;
  logic [XLEN-1:0] alu_result;
  logic            accept;
  logic            in_resp;
  logic            unused_pc_bits;

  assign accept         = (state == IDLE) && bus.I_req_valid;
  assign in_resp        = (state == RESP);
  assign unused_pc_bits = ^pc_q[1:0];

  ysyx_22040750_csr_alu #(.XLEN(XLEN)) u_alu (
    .csr     (old_q),
    .rs_data (rs_q),
    .uimm    (uimm_q),
    .op_sel  (op_q),
    .result  (alu_result)
  );

  // Decode the latched CSR address into a hit flag and the current CSR value
  always_comb begin
    rd_hit = 1'b1;
    rd_val = '0;
    case (addr_q)
      CSR_MSTATUS:  rd_val = mstatus;
      CSR_MTVEC:    rd_val = mtvec;
      CSR_MEPC:     rd_val = mepc;
      CSR_MCAUSE:   rd_val = mcause;
`ifdef YSYX_22040750_CSR_MSCRATCH_EN
      CSR_MSCRATCH: rd_val = mscratch;
`endif
      default:      rd_hit = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: route a new request by type, then walk its sequence
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.I_req_valid) begin
          case (req_type_e'(bus.I_req_type))
            REQ_CSR:   next_state = CSR_RD;
            REQ_ECALL: next_state = TRAP_EPC;
            REQ_MRET:  next_state = RET;
            default:   next_state = RESP;
          endcase
        end
      end
      CSR_RD:     next_state = rd_hit ? CSR_WR : RESP;
      CSR_WR:     next_state = RESP;
      TRAP_EPC:   next_state = TRAP_CAUSE;
      TRAP_CAUSE: next_state = TRAP_STAT;
      TRAP_STAT:  next_state = RESP;
      RET:        next_state = RESP;
      RESP:       if (bus.I_resp_ready) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Request latches, response registers and CSR storage updated per state
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      addr_q           <= '0;
      op_q             <= '0;
      rs_q             <= '0;
      uimm_q           <= '0;
      pc_q             <= '0;
      old_q            <= '0;
      illegal_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mstatus          <= XLEN'(MSTATUS_RESET);
      mtvec            <= '0;
      mepc             <= '0;
      mcause           <= '0;
`ifdef YSYX_22040750_CSR_MSCRATCH_EN
      mscratch         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q           <= bus.I_csr_addr;
            op_q             <= bus.I_csr_op_sel;
            rs_q             <= bus.I_rs_data;
            uimm_q           <= bus.I_uimm;
            pc_q             <= bus.I_pc;
            old_q            <= '0;
            illegal_q        <= (bus.I_req_type == REQ_RSVD);
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
          end
        end
        CSR_RD: begin
          if (rd_hit) old_q     <= rd_val;
          else        illegal_q <= 1'b1;
        end
        CSR_WR: begin
          if (|op_q) begin
            case (addr_q)
              CSR_MSTATUS:  mstatus  <= alu_result;
              CSR_MTVEC:    mtvec    <= {alu_result[XLEN-1:2], 2'b00};
              CSR_MEPC:     mepc     <= {alu_result[XLEN-1:2], 2'b00};
              CSR_MCAUSE:   mcause   <= alu_result;
`ifdef YSYX_22040750_CSR_MSCRATCH_EN
              CSR_MSCRATCH: mscratch <= alu_result;
`endif
              default: ;
            endcase
          end
        end
        TRAP_EPC:   mepc   <= {pc_q[XLEN-1:2], 2'b00};
        TRAP_CAUSE: mcause <= MCAUSE_ECALL;
        TRAP_STAT: begin
          mstatus[MSTATUS_MPIE]                  <= mstatus[MSTATUS_MIE];
          mstatus[MSTATUS_MIE]                   <= 1'b0;
          mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
          redirect_valid_q                       <= 1'b1;
          redirect_pc_q                          <= mtvec;
        end
        RET: begin
          mstatus[MSTATUS_MIE]                   <= mstatus[MSTATUS_MPIE];
          mstatus[MSTATUS_MPIE]                  <= 1'b1;
          mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
          redirect_valid_q                       <= 1'b1;
          redirect_pc_q                          <= mepc;
        end
        default: ;
      endcase
    end
  end

  assign bus.O_req_ready      = (state == IDLE);
  assign bus.O_resp_valid     = in_resp;
  assign bus.O_rd_data        = in_resp ? old_q : '0;
  assign bus.O_illegal        = in_resp & illegal_q;
  assign bus.O_redirect_valid = in_resp & redirect_valid_q;
  assign bus.O_redirect_pc    = in_resp ? redirect_pc_q : '0;

endmodule

// File: tb/tb_ysyx_22040750_csr_ctrl.sv
// Self-checking bench for ysyx_22040750_csr_ctrl: directed steps followed by
// randomized requests, compared against an architectural CSR model.
// Honours YSYX_22040750_CSR_MSCRATCH_EN to match the build of the design.
module tb_ysyx_22040750_csr_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  // Architectural CSR state as the model sees it
  logic [63:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mscratch;

  // Expected response of the request currently being applied
  logic [63:0] e_rd, e_rpc;
  logic        e_ill, e_rv;
  int          e_lat;

  always #5 clk = ~clk;

  ysyx_22040750_csr_ctrl_if #(.XLEN(64)) bus ();

  ysyx_22040750_csr_ctrl dut (
    .I_sys_clk (clk),
    .I_rst     (rst),
    .bus       (bus)
  );

  // Hard stop in case something deadlocks
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void model_reset();
    m_mstatus  = 64'h0000_000a_0000_1800;
    m_mtvec    = '0;
    m_mepc     = '0;
    m_mcause   = '0;
    m_mscratch = '0;
  endfunction

  function automatic bit model_implemented(input logic [11:0] a);
`ifdef YSYX_22040750_CSR_MSCRATCH_EN
    if (a == 12'h340) return 1'b1;
`endif
    return (a == 12'h300) || (a == 12'h305) || (a == 12'h341) || (a == 12'h342);
  endfunction

  function automatic logic [63:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h340: return m_mscratch;
      default: return 64'd0;
    endcase
  endfunction

  function automatic void model_write(input logic [11:0] a, input logic [63:0] v);
    case (a)
      12'h300: m_mstatus  = v;
      12'h305: m_mtvec    = v & ~64'h3;
      12'h341: m_mepc     = v & ~64'h3;
      12'h342: m_mcause   = v;
      12'h340: m_mscratch = v;
      default: ;
    endcase
  endfunction

  // Architectural effect of one request plus its expected response and latency
  function automatic void model_request(input logic [1:0] t, input logic [11:0] a,
                                        input logic [5:0] op, input logic [63:0] rs,
                                        input logic [4:0] u, input logic [63:0] pc);
    logic [63:0] operand, nv;
    e_rd = '0; e_rpc = '0; e_ill = 1'b0; e_rv = 1'b0;
    case (t)
      2'b00: begin
        if (model_implemented(a)) begin
          e_rd  = model_read(a);
          e_lat = 3;
          if (op != 6'd0) begin
            operand = (op[2:0] != 3'd0) ? {59'd0, u} : rs;
            if (op[5] || op[2])      nv = operand;
            else if (op[4] || op[1]) nv = e_rd | operand;
            else                     nv = e_rd & ~operand;
            model_write(a, nv);
          end
        end else begin
          e_ill = 1'b1;
          e_lat = 2;
        end
      end
      2'b01: begin
        m_mepc           = {pc[63:2], 2'b00};
        m_mcause         = 64'd11;
        m_mstatus[7]     = m_mstatus[3];
        m_mstatus[3]     = 1'b0;
        m_mstatus[12:11] = 2'b11;
        e_rv  = 1'b1;
        e_rpc = m_mtvec;
        e_lat = 4;
      end
      2'b10: begin
        e_rv  = 1'b1;
        e_rpc = m_mepc;
        m_mstatus[3]     = m_mstatus[7];
        m_mstatus[7]     = 1'b1;
        m_mstatus[12:11] = 2'b11;
        e_lat = 2;
      end
      default: begin
        e_ill = 1'b1;
        e_lat = 1;
      end
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_response(input string tag);
    check_output({tag, "_rd_data"},  bus.O_rd_data, e_rd);
    check_output({tag, "_illegal"},  64'(bus.O_illegal), 64'(e_ill));
    check_output({tag, "_redir_v"},  64'(bus.O_redirect_valid), 64'(e_rv));
    check_output({tag, "_redir_pc"}, bus.O_redirect_pc, e_rpc);
  endtask

  // Issue one request from a negedge, measure latency, hold the response
  // for 'hold' cycles, complete the handshake and return on a negedge.
  task automatic apply_stimulus(input string tag, input logic [1:0] t, input logic [11:0] a,
                                input logic [5:0] op, input logic [63:0] rs,
                                input logic [4:0] u, input logic [63:0] pc, input int hold);
    int lat;
    model_request(t, a, op, rs, u, pc);
    bus.I_req_valid  = 1'b1;
    bus.I_req_type   = t;
    bus.I_csr_addr   = a;
    bus.I_csr_op_sel = op;
    bus.I_rs_data    = rs;
    bus.I_uimm       = u;
    bus.I_pc         = pc;
    check_output({tag, "_req_ready"}, 64'(bus.O_req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.I_req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.O_resp_valid && lat < 20);
    check_output({tag, "_latency"}, 64'(lat), 64'(e_lat));
    check_response(tag);
    for (int i = 0; i < hold; i++) begin
      bus.I_req_valid = 1'b1;
      @(negedge clk);
      check_output({tag, "_hold_valid"}, 64'(bus.O_resp_valid), 64'd1);
      check_output({tag, "_hold_ready"}, 64'(bus.O_req_ready), 64'd0);
      check_response({tag, "_hold"});
    end
    bus.I_req_valid  = 1'b0;
    bus.I_resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.I_resp_ready = 1'b0;
    @(negedge clk);
    check_output({tag, "_after_ready"}, 64'(bus.O_req_ready), 64'd1);
    check_output({tag, "_after_valid"}, 64'(bus.O_resp_valid), 64'd0);
  endtask

  task automatic read_all(input string tag);
    apply_stimulus({tag, "_mstatus"},  2'b00, 12'h300, 6'd0, 64'd0, 5'd0, 64'd0, 0);
    apply_stimulus({tag, "_mtvec"},    2'b00, 12'h305, 6'd0, 64'd0, 5'd0, 64'd0, 0);
    apply_stimulus({tag, "_mepc"},     2'b00, 12'h341, 6'd0, 64'd0, 5'd0, 64'd0, 0);
    apply_stimulus({tag, "_mcause"},   2'b00, 12'h342, 6'd0, 64'd0, 5'd0, 64'd0, 0);
    apply_stimulus({tag, "_mscratch"}, 2'b00, 12'h340, 6'd0, 64'd0, 5'd0, 64'd0, 0);
  endtask

  initial begin
    logic [11:0] addr_tab [6];
    logic [1:0]  rt;
    logic [5:0]  rop;
    int          r;

    addr_tab = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7c0};
    bus.I_req_valid  = 1'b0;
    bus.I_req_type   = 2'b00;
    bus.I_csr_addr   = '0;
    bus.I_csr_op_sel = '0;
    bus.I_rs_data    = '0;
    bus.I_uimm       = '0;
    bus.I_pc         = '0;
    bus.I_resp_ready = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("reset_req_ready", 64'(bus.O_req_ready), 64'd1);
    check_output("reset_resp_valid", 64'(bus.O_resp_valid), 64'd0);
    check_output("reset_rd_data", bus.O_rd_data, 64'd0);
    check_output("reset_redir_v", 64'(bus.O_redirect_valid), 64'd0);

    // mtvec write with mode bits forced to direct
    apply_stimulus("csrrw_mtvec", 2'b00, 12'h305, 6'b100000, 64'h8000_0103, 5'd0, 64'd0, 0);
    apply_stimulus("csrr_mtvec",  2'b00, 12'h305, 6'b000000, 64'd0, 5'd0, 64'd0, 0);

    // mstatus immediate clear / set of MIE
    apply_stimulus("csrr_mstatus",   2'b00, 12'h300, 6'b000000, 64'd0, 5'd0, 64'd0, 0);
    apply_stimulus("csrrci_mstatus", 2'b00, 12'h300, 6'b000001, 64'd0, 5'h8, 64'd0, 0);
    apply_stimulus("csrr_mstatus2",  2'b00, 12'h300, 6'b000000, 64'd0, 5'd0, 64'd0, 0);
    apply_stimulus("csrrsi_mstatus", 2'b00, 12'h300, 6'b000010, 64'd0, 5'h8, 64'd0, 0);
    apply_stimulus("csrr_mstatus3",  2'b00, 12'h300, 6'b000000, 64'd0, 5'd0, 64'd0, 0);

    // Trap entry and return
    apply_stimulus("ecall", 2'b01, 12'h000, 6'd0, 64'd0, 5'd0, 64'h8000_0010, 0);
    read_all("post_ecall");
    apply_stimulus("mret", 2'b10, 12'h000, 6'd0, 64'd0, 5'd0, 64'h8000_0040, 0);
    apply_stimulus("post_mret_mstatus", 2'b00, 12'h300, 6'd0, 64'd0, 5'd0, 64'd0, 0);

    // Response held by the consumer
    apply_stimulus("hold_mepc", 2'b00, 12'h341, 6'd0, 64'd0, 5'd0, 64'd0, 5);

    // mscratch (build dependent), unimplemented address, reserved type
    apply_stimulus("csrrw_mscratch", 2'b00, 12'h340, 6'b100000, 64'h55, 5'd0, 64'd0, 0);
    apply_stimulus("csrr_mscratch",  2'b00, 12'h340, 6'b000000, 64'd0, 5'd0, 64'd0, 0);
    apply_stimulus("csrrw_7c0",      2'b00, 12'h7c0, 6'b100000, 64'hdead, 5'd0, 64'd0, 0);
    apply_stimulus("rsvd_type",      2'b11, 12'h300, 6'b100000, 64'hffff, 5'd0, 64'h1234, 1);
    read_all("post_illegal");

    // Randomized mix of all request kinds
    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 9);
      rt = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      r  = $urandom_range(0, 6);
      rop = (r == 0) ? 6'd0 : 6'(1 << (r - 1));
      apply_stimulus($sformatf("rand%0d", n), rt, addr_tab[$urandom_range(0, 5)], rop,
                     {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom},
                     $urandom_range(0, 2));
    end

    // Reset during TRAP_CAUSE of an ecall discards everything
    apply_stimulus("pre_rst_mtvec", 2'b00, 12'h305, 6'b100000, 64'h8000_0200, 5'd0, 64'd0, 0);
    bus.I_req_valid = 1'b1;
    bus.I_req_type  = 2'b01;
    bus.I_pc        = 64'h8000_0abc;
    @(posedge clk);
    #1;
    bus.I_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("midrst_req_ready", 64'(bus.O_req_ready), 64'd1);
    check_output("midrst_resp_valid", 64'(bus.O_resp_valid), 64'd0);
    model_reset();
    read_all("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22040750_csr_ctrl.md
# ysyx_22040750_csr_ctrl

Sequencing controller for the machine-mode CSR file in the NPC pipeline's execute stage. Accepts one CSR instruction, ecall or mret at a time from execute and serialises the read / ALU / write-back of the CSR read-modify-write datapath. Sequences multi-register trap entry and trap return, and returns the old CSR value plus an optional PC redirect. Owns the CSR storage: mstatus, mtvec, mepc, mcause, and optionally mscratch.

## Interface
Parameters:
- XLEN, 64, data width
- MCAUSE_ECALL, 64'd11, cause code written on ecall (ecall from M-mode)

Ports:
- I_sys_clk  in  1  clock; all state updates on rising edge
- I_rst  in  1  synchronous, active-high reset
- I_req_valid  in  1  request present
- O_req_ready  out  1  controller can accept a request
- I_req_type  in  2  00 CSR op, 01 ecall, 10 mret, 11 reserved (treated as illegal)
- I_csr_addr  in  12  CSR address (CSR op only)
- I_csr_op_sel  in  6  one-hot {rw, rs, rc, rwi, rsi, rci}; all-zero = read-only
- I_rs_data  in  XLEN  rs1 value
- I_uimm  in  5  zimm field
- I_pc  in  XLEN  PC of the requesting instruction
- O_resp_valid  out  1  response present
- I_resp_ready  in  1  consumer accepts response
- O_rd_data  out  XLEN  CSR value before the write; 0 for ecall, mret or illegal
- O_illegal  out  1  unimplemented CSR address or reserved type
- O_redirect_valid  out  1  O_redirect_pc is valid (ecall or mret)
- O_redirect_pc  out  XLEN  trap target or return address

## Operation
- FSM states: IDLE, CSR_RD, CSR_WR, TRAP_EPC, TRAP_CAUSE, TRAP_STAT, RET, RESP.
- IDLE: O_req_ready=1. On I_req_valid, latch all request fields and route by type:
  - CSR op -> CSR_RD
  - ecall -> TRAP_EPC
  - mret -> RET
  - reserved type -> RESP with O_illegal=1
- CSR_RD: read the addressed CSR into old_q. An unimplemented address sets illegal_q and goes to RESP with no write.
- CSR_WR: new value = ALU(old_q, rs, uimm, op_sel). Write only if |op_sel; then go to RESP.
- ALU rules:
  - rw: result = op
  - rs: result = csr | op
  - rc: result = csr & ~op
  - op = rs_data for rw/rs/rc; {59'b0, uimm} for the imm variants
- mtvec writes force bits[1:0]=0 (direct mode only). mepc writes force bit[1:0]=0.
- TRAP_EPC: mepc <= {pc[63:2], 2'b00}.
- TRAP_CAUSE: mcause <= MCAUSE_ECALL.
- TRAP_STAT: MPIE <= MIE, MIE <= 0, MPP <= 2'b11. Redirect target = mtvec.
- RET: MIE <= MPIE, MPIE <= 1, MPP <= 2'b11. Redirect target = mepc.
- RESP: O_resp_valid=1 with stable outputs until I_resp_ready, then IDLE.
- Reset values:
  - mstatus = 64'h0000_000a_0000_1800; mtvec, mepc, mcause, mscratch = 0
  - all outputs 0; FSM in IDLE (O_req_ready=1 from the first cycle after reset deasserts)
- Reset asserted mid-sequence aborts the operation and resets all state; partially updated trap registers are discarded by reset.

## Timing
- Accept at cycle T (valid & ready). Response first visible:
  - CSR op: T+3
  - ecall: T+4
  - mret: T+2
  - illegal type: T+1
- Only one request in flight. O_req_ready=0 from T+1 until the cycle after the RESP handshake.
- Back-to-back: a request may be accepted the cycle after the handshake. It sees every CSR write of the previous request (no bypass needed).
- O_resp_valid, once high, holds with all outputs unchanged until I_resp_ready=1.

## Configuration
- YSYX_22040750_CSR_MSCRATCH_EN defined: mscratch (0x340) is implemented, read/write, reset 0.
- Macro undefined: 0x340 is unimplemented. Access returns O_illegal=1, O_rd_data=0, no state change.
- Implemented addresses otherwise: 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause.

## Structure
- Shared package ysyx_22040750_csr_pkg holds:
  - CSR address constants
  - req_type encodings
  - op_sel bit positions
  - mstatus field indices (MIE=3, MPIE=7, MPP=12:11)
  - mstatus reset constant
  - FSM state enum
- One sub-module: ysyx_22040750_csr_alu (the existing combinational CSR ALU), instantiated once for the CSR_WR result. The controller itself holds the FSM, request latches and CSR registers.

## Test plan
- After reset, csrrw mtvec with rs=0x8000_0103 -> resp at T+3, rd_data=0, then csrr mtvec returns 0x8000_0100.
- mstatus reset value, then csrrci mstatus uimm=0x8 -> rd_data=0xa_0000_1800; a follow-up read returns 0xa_0000_1800 (MIE already 0). csrrsi uimm=0x8 -> subsequent read 0xa_0000_1808.
- mstatus=...1808, ecall pc=0x8000_0010 -> resp at T+4, redirect_pc=mtvec, mepc=0x8000_0010, mcause=11, mstatus MIE=0, MPIE=1. Then mret -> resp at T+2, redirect_pc=0x8000_0010, MIE=1, MPIE=1.
- Hold I_resp_ready=0 for 5 cycles after a csrr -> outputs stable, O_req_ready=0, a second request is not accepted until the cycle after the handshake.
- csrrw 0x340 rs=0x55 -> with macro: rd_data=0, readback 0x55. Without macro: O_illegal=1, rd_data=0. Also csrrw 0x7c0 -> O_illegal=1, no CSR changed.
- Assert I_rst during TRAP_CAUSE of an ecall -> next cycle IDLE, all CSRs at reset values, O_resp_valid=0.
